// File: rtl/mem_responder_if.sv
// ============================================================================
// mem_responder_if : MAR/MDR request/response bundle between datapath and RAM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              Read;
    logic              Write;
    logic [31:0]       MAR_addr;
    logic [DATA_W-1:0] MDR_data;
    logic [DATA_W-1:0] Mdatain;
    logic              Busy;
    logic              Done;
    logic              Range_err;

    modport master (
        output Read, Write, MAR_addr, MDR_data,
        input  Mdatain, Busy, Done, Range_err
    );

    modport slave (
        input  Read, Write, MAR_addr, MDR_data,
        output Mdatain, Busy, Done, Range_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : word-addressed RAM with fixed wait states and Busy/Done
//                 handshake. Optional MEM_RANGE_CHECK_EN flags and suppresses
//                 accesses with address bits set above ADDR_W-1.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic       clock,
    input  wire logic       clear,
    mem_responder_if.slave  bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

`ifdef MEM_RANGE_CHECK_EN
    localparam bit c_RANGE_CHECK = 1'b1;
`else
    localparam bit c_RANGE_CHECK = 1'b0;
`endif

    logic [1:0]        r_state;
    logic [3:0]        r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rdata;
    logic              r_op_read;
    logic              r_oob;
    logic              r_busy;
    logic              r_done;
    logic              r_range_err;
    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    logic w_oob;
    logic w_req;
    logic w_mem_we;

    // Without range checking the upper address bits simply alias.
    assign w_oob    = c_RANGE_CHECK && (|bus.MAR_addr[31:ADDR_W]);
    assign w_req    = bus.Read | bus.Write;
    assign w_mem_we = (r_state == c_ACCESS) && !r_op_read && !r_oob && !clear;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state     <= c_IDLE;
            r_count     <= 4'd0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rdata     <= '0;
            r_op_read   <= 1'b0;
            r_oob       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_range_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_addr    <= bus.MAR_addr[ADDR_W-1:0];
                        r_data    <= bus.MDR_data;
                        r_op_read <= bus.Read;
                        r_oob     <= w_oob;
                        r_busy    <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= c_ACCESS;
                        end else begin
                            r_state <= c_WAIT;
                            r_count <= c_WAIT_INIT;
                        end
                    end
                end
                c_WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    if (r_op_read) begin
                        r_rdata <= r_oob ? '0 : r_mem[r_addr];
                    end
                    r_state     <= c_DONE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_range_err <= r_oob;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Array has no reset; an aborted write never reaches this edge.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_data;
        end
    end

    assign bus.Mdatain   = r_rdata;
    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.Range_err = r_range_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : directed self-checking bench for mem_responder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

`ifdef MEM_RANGE_CHECK_EN
    localparam bit c_RC = 1'b1;
`else
    localparam bit c_RC = 1'b0;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mem_responder_if #(.DATA_W(32)) bus0 ();
    mem_responder_if #(.DATA_W(32)) bus1 ();

    mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(2)) u_dut_w2 (
        .clock (clk),
        .clear (rst),
        .bus   (bus0)
    );

    mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) u_dut_w0 (
        .clock (clk),
        .clear (rst),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one transaction on the WAIT_CYCLES=2 instance; returns in the
    // following IDLE cycle with Done-cycle observations captured.
    task automatic xact0(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, output int busy_cyc,
                         output int done_edge, output logic rerr, output logic [31:0] rdata);
        bus0.Read     = rd;
        bus0.Write    = wr;
        bus0.MAR_addr = addr;
        bus0.MDR_data = data;
        busy_cyc  = 0;
        done_edge = -1;
        rerr      = 1'bx;
        rdata     = 'x;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (bus0.Busy === 1'b1) busy_cyc++;
            if (bus0.Done === 1'b1) begin
                done_edge = e;
                rerr      = bus0.Range_err;
                rdata     = bus0.Mdatain;
                break;
            end
        end
        bus0.Read  = 1'b0;
        bus0.Write = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          busy_cyc, done_edge;
        logic        rerr;
        logic [31:0] rdata;
        int          first, last, ndone, run, maxrun, gap_bad, data_bad, w0_done;

        tests = 0;
        fails = 0;
        rst   = 1'b0;
        bus0.Read = 1'b0; bus0.Write = 1'b0; bus0.MAR_addr = '0; bus0.MDR_data = '0;
        bus1.Read = 1'b0; bus1.Write = 1'b0; bus1.MAR_addr = '0; bus1.MDR_data = '0;

        // Asynchronous clear mid-cycle, checked before any clock edge
        #12 rst = 1'b1;
        #1;
        check("rst_mdatain", bus0.Mdatain, 32'h0);
        check("rst_busy", {31'b0, bus0.Busy}, 32'h0);
        check("rst_done", {31'b0, bus0.Done}, 32'h0);
        check("rst_range", {31'b0, bus0.Range_err}, 32'h0);
        #5 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_mdatain", bus0.Mdatain, 32'h0);
        check("idle_busy", {31'b0, bus0.Busy}, 32'h0);
        check("idle_done", {31'b0, bus0.Done}, 32'h0);

        // Write then read back, WAIT_CYCLES=2
        xact0(1'b0, 1'b1, 32'h12, 32'hDEADBEEF, busy_cyc, done_edge, rerr, rdata);
        check("wr_busy_cycles", busy_cyc, 32'd3);
        check("wr_done_edge", done_edge, 32'd4);
        check("wr_range", {31'b0, rerr}, 32'h0);
        xact0(1'b1, 1'b0, 32'h12, 32'h0, busy_cyc, done_edge, rerr, rdata);
        check("rd_busy_cycles", busy_cyc, 32'd3);
        check("rd_done_edge", done_edge, 32'd4);
        check("rd_data", rdata, 32'hDEADBEEF);
        check("rd_data_held", bus0.Mdatain, 32'hDEADBEEF);

        // Read+Write together behaves as a read
        xact0(1'b0, 1'b1, 32'h5, 32'h11, busy_cyc, done_edge, rerr, rdata);
        xact0(1'b1, 1'b1, 32'h5, 32'h22, busy_cyc, done_edge, rerr, rdata);
        check("rw_data", rdata, 32'h11);
        xact0(1'b1, 1'b0, 32'h5, 32'h0, busy_cyc, done_edge, rerr, rdata);
        check("rw_readback", rdata, 32'h11);

        // Abort a write during WAIT
        xact0(1'b0, 1'b1, 32'h7, 32'h0, busy_cyc, done_edge, rerr, rdata);
        bus0.Write = 1'b1; bus0.MAR_addr = 32'h7; bus0.MDR_data = 32'hAAAA5555;
        @(posedge clk); #1;
        bus0.Write = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", {31'b0, bus0.Busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, bus0.Busy}, 32'h0);
        check("abort_done", {31'b0, bus0.Done}, 32'h0);
        check("abort_mdatain", bus0.Mdatain, 32'h0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        xact0(1'b1, 1'b0, 32'h7, 32'h0, busy_cyc, done_edge, rerr, rdata);
        check("abort_readback", rdata, 32'h0);

        // WAIT_CYCLES=0: seed word 3, then hold Read high
        bus1.Write = 1'b1; bus1.MAR_addr = 32'h3; bus1.MDR_data = 32'h33;
        w0_done = -1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (bus1.Done === 1'b1) begin
                w0_done = e;
                break;
            end
        end
        bus1.Write = 1'b0;
        check("w0_write_done_edge", w0_done, 32'd2);
        @(posedge clk); #1;
        bus1.Read = 1'b1;
        first = -1; last = -1; ndone = 0; run = 0; maxrun = 0; gap_bad = 0; data_bad = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (bus1.Busy === 1'b1) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (bus1.Done === 1'b1) begin
                ndone++;
                if (first < 0) first = e;
                else if (e - last != 3) gap_bad++;
                last = e;
                if (bus1.Mdatain !== 32'h33) data_bad++;
            end
        end
        bus1.Read = 1'b0;
        check("w0_first_done", first, 32'd2);
        check("w0_done_count", ndone, 32'd4);
        check("w0_done_gap_bad", gap_bad, 32'd0);
        check("w0_busy_maxrun", maxrun, 32'd1);
        check("w0_data_bad", data_bad, 32'd0);

        // Out-of-range / aliasing behaviour
        xact0(1'b0, 1'b1, 32'h0, 32'hA5, busy_cyc, done_edge, rerr, rdata);
        xact0(1'b0, 1'b1, 32'h200, 32'h1, busy_cyc, done_edge, rerr, rdata);
        check("oob_wr_done_edge", done_edge, 32'd4);
        check("oob_wr_range", {31'b0, rerr}, c_RC ? 32'h1 : 32'h0);
        check("oob_range_after", {31'b0, bus0.Range_err}, 32'h0);
        xact0(1'b1, 1'b0, 32'h0, 32'h0, busy_cyc, done_edge, rerr, rdata);
        check("word0_data", rdata, c_RC ? 32'hA5 : 32'h1);
        check("word0_range", {31'b0, rerr}, 32'h0);
        xact0(1'b1, 1'b0, 32'h200, 32'h0, busy_cyc, done_edge, rerr, rdata);
        check("oob_rd_data", rdata, c_RC ? 32'h0 : 32'h1);
        check("oob_rd_range", {31'b0, rerr}, c_RC ? 32'h1 : 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed RAM that serves as the memory end of the datapath's MAR/MDR interface.
- Takes Read/Write strobes, the MAR address and MDR write data; returns read data on Mdatain, which feeds the datapath's MDR input mux.
- Fixed, parameterised wait-state latency, with a Busy/Done handshake so the control unit can stall.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 9, address bits used; depth is 2**ADDR_W words.
- WAIT_CYCLES, 2, wait states before the array access; legal range 0..15.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- Read  in  1  read request level, sampled in IDLE.
- Write  in  1  write request level, sampled in IDLE.
- MAR_addr  in  32  word address from MAR.
- MDR_data  in  DATA_W  write data from MDR.
- Mdatain  out  DATA_W  read data to the datapath MDR mux.
- Busy  out  1  transaction in progress (WAIT or ACCESS).
- Done  out  1  one-cycle completion pulse.
- Range_err  out  1  out-of-range flag; see Optional Feature.

Behaviour:
- Reset: clear is asynchronous and active-high. Reset values: state=IDLE, Mdatain=0, Busy=0, Done=0, Range_err=0, wait counter=0.
- Reset does not initialise memory contents.
- All outputs are registered.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - Read or Write high at an edge: latch addr=MAR_addr[ADDR_W-1:0], latch data=MDR_data, latch op.
  - Then go to WAIT with counter=WAIT_CYCLES, or straight to ACCESS if WAIT_CYCLES=0.
  - Read and Write both high: treated as a read; the write is dropped.
- WAIT: counter decrements each edge. At an edge where counter==1, go to ACCESS. WAIT therefore lasts exactly WAIT_CYCLES cycles.
- ACCESS (one cycle):
  - Read: Mdatain<=mem[addr] on the exit edge.
  - Write: mem[addr]<=data on the exit edge; Mdatain unchanged.
  - Next state is DONE.
- DONE (one cycle): Done=1, Busy=0; next state is IDLE.
- Busy=1 exactly in WAIT and ACCESS.
- Latency: counting the sampling edge as edge 1, Done is high in the cycle after edge WAIT_CYCLES+2, and read data is valid on Mdatain in that same cycle.
- Mdatain holds its value until the next completed read.
- Request inputs, MAR_addr and MDR_data are ignored outside IDLE; changing them mid-transaction has no effect.
- Requester must drop its strobe on seeing Done. A strobe still high in IDLE starts a new transaction, so back-to-back requests are one IDLE cycle apart.
- clear mid-transaction:
  - Immediate return to IDLE with all outputs at reset values.
  - A pending write is not performed, because the array is written only on the ACCESS exit edge.
  - A pending read leaves Mdatain=0.
- Address wrap: without the feature, address bits above ADDR_W-1 are ignored, so address 2**ADDR_W aliases to word 0.
- Read-after-write to the same address returns the new data, since the write is complete before the next transaction is sampled.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined:
  - The IDLE sampling edge also latches oob=|MAR_addr[31:ADDR_W].
  - An oob transaction keeps the same latency.
  - Write is suppressed; memory is unchanged.
  - Read loads Mdatain=0.
  - Range_err=1 in the DONE cycle only, coincident with Done; otherwise 0.
- Undefined: Range_err is tied 0 and the aliasing rule applies.

Test Plan:
- Reset then idle: clear pulsed mid-cycle asynchronously -> Mdatain=0, Busy=0, Done=0 immediately, and they stay 0 with no requests.
- Write/read, WAIT_CYCLES=2:
  - Stimulus: Write, MAR_addr=0x12, MDR_data=0xDEADBEEF until Done; then Read, addr 0x12.
  - Required: Busy high 3 cycles, Done one cycle after edge 4, Mdatain=0xDEADBEEF in the read's Done cycle.
- Simultaneous Read+Write:
  - Stimulus: mem[5]=0x11; Read=Write=1, addr 5, data 0x22.
  - Required: Mdatain=0x11; a following read of addr 5 returns 0x11.
- Abort: Write addr 7 data 0xAAAA5555, clear asserted during WAIT -> all outputs 0; a later read of addr 7 returns its prior value 0x0.
- WAIT_CYCLES=0 and held strobe:
  - Stimulus: Read held high continuously.
  - Required: Done pulses every 3 cycles (ACCESS, DONE, IDLE); Busy is never high for more than 1 cycle.
- Range, with MEM_RANGE_CHECK_EN:
  - Stimulus: write 0x1 to addr 0x200, then read addr 0x000.
  - Required: Range_err=1 with Done on the write; the read returns the old word-0 value.
  - Without the macro: word 0 = 0x1 (alias), Range_err=0.
